// File: rtl/uart1_transmitter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart1_transmitter_if
// Description : CPU-side register bus of the UART1 window. The decoder
//               select, the 12-bit window offset, the read/write strobes and
//               both data paths travel together as one bundle.
//               master = CPU / address-decoder side, slave = UART1 side.
// Revision    : 1.0  initial release
// ============================================================================
interface uart1_transmitter_if;

   logic        sel;      // UART1 window selected by the address decoder
   logic [11:0] offset;   // address[11:0] inside the window
   logic        write;    // write strobe
   logic        read;     // read strobe
   logic [7:0]  wdata;    // write data
   logic [7:0]  rdata;    // registered read data

   modport master (
      output sel,
      output offset,
      output write,
      output read,
      output wdata,
      input  rdata
   );

   modport slave (
      input  sel,
      input  offset,
      input  write,
      input  read,
      input  wdata,
      output rdata
   );

endinterface

`default_nettype wire

// File: rtl/uart1_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart1_transmitter
// Description : Memory-mapped 8N1 UART transmitter. CPU writes to TXDATA are
//               queued in a small circular FIFO; a baud-timed state machine
//               pops bytes and shifts them out on tx, LSB first, with no idle
//               gap between queued frames.
//               Register map (when sel=1):
//                 0x000 TXDATA  write-only, pushes wdata
//                 0x004 STATUS  read-only, {4'b0, overflow, busy,
//                               fifo_empty, fifo_full}; a read clears the
//                               sticky overflow flag
//               Build option: define UART1_PARITY_EN to insert an even-parity
//               bit between the data bits and the stop bit (11-bit frame).
// Revision    : 1.0  initial release
// ============================================================================
module uart1_transmitter #(
   parameter int CLKS_PER_BIT = 868,   // clock cycles per serial bit
   parameter int FIFO_DEPTH   = 4      // TX FIFO entries, power of two, >= 2
) (
   input  wire                  clk,
   input  wire                  nRESET,   // synchronous, active low
   uart1_transmitter_if.slave   bus,
   output logic                 tx,
   output logic                 busy
);

   // ------------------------------------------------------------------------
   // Derived sizes and constants
   // ------------------------------------------------------------------------
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
   localparam logic [11:0]       OFF_TXDATA = 12'h000;
   localparam logic [11:0]       OFF_STATUS = 12'h004;

   // ------------------------------------------------------------------------
   // Serialiser states
   // ------------------------------------------------------------------------
`ifdef UART1_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_PARITY = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3
   } state_t;
`endif

   state_t              state;
   logic [BAUD_W-1:0]   baud_cnt;    // cycles elapsed in the current bit
   logic [2:0]          bit_idx;     // data bit being driven, 0..7
   logic [7:0]          shifter;     // byte of the frame in flight
   logic [2:0]          next_bit;

   // ------------------------------------------------------------------------
   // FIFO storage and bookkeeping
   // ------------------------------------------------------------------------
   logic [7:0]          fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                overflow;

   logic                fifo_empty;
   logic                fifo_full;
   logic                baud_last;
   logic                pop;
   logic                push_req;
   logic                push;
   logic                ovf_event;
   logic                status_rd;
   logic [7:0]          head;
   logic [7:0]          status;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_FULL);
   assign baud_last  = (baud_cnt == BAUD_LAST);
   assign head       = fifo_mem[rd_ptr];
   assign next_bit   = bit_idx + 3'd1;

   // The serialiser takes a byte either from idle or on the very last cycle
   // of a stop bit, which is what keeps back-to-back frames gap-free.
   assign pop = ~fifo_empty &
                ((state == S_IDLE) | ((state == S_STOP) & baud_last));

   // A push into a full FIFO still succeeds when the same edge pops, since
   // the slot being vacated is reused; only a push with no room is dropped.
   assign push_req  = bus.sel & bus.write & (bus.offset == OFF_TXDATA);
   assign push      = push_req & (~fifo_full | pop);
   assign ovf_event = push_req & fifo_full & ~pop;
   assign status_rd = bus.sel & bus.read & (bus.offset == OFF_STATUS);

   assign busy   = (state != S_IDLE) | ~fifo_empty;
   assign status = {4'b0000, overflow, busy, fifo_empty, fifo_full};

   // FIFO data array: written on every accepted push; contents need no reset
   // because the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= bus.wdata;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag: a new overflow wins over a same-edge STATUS read clear.
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         overflow <= 1'b0;
      end else if (ovf_event) begin
         overflow <= 1'b1;
      end else if (status_rd) begin
         overflow <= 1'b0;
      end
   end

   // Read data register: loaded on every read strobe, held otherwise; only
   // a selected STATUS read returns something other than zero.
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         bus.rdata <= 8'h00;
      end else if (bus.read) begin
         bus.rdata <= status_rd ? status : 8'h00;
      end
   end

   // Baud-timed serialiser: each state lasts CLKS_PER_BIT cycles and tx is
   // registered, so the line level for a bit is set on the edge entering it.
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shifter  <= 8'h00;
         tx       <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= 3'd0;
               if (pop) begin
                  shifter <= head;
                  state   <= S_START;
                  tx      <= 1'b0;
               end else begin
                  tx      <= 1'b1;
               end
            end

            S_START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_idx  <= 3'd0;
                  state    <= S_DATA;
                  tx       <= shifter[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef UART1_PARITY_EN
                     state <= S_PARITY;
                     tx    <= ^shifter;
`else
                     state <= S_STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bit_idx <= next_bit;
                     tx      <= shifter[next_bit];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

`ifdef UART1_PARITY_EN
            S_PARITY: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  state    <= S_STOP;
                  tx       <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_idx  <= 3'd0;
                  if (pop) begin
                     shifter <= head;
                     state   <= S_START;
                     tx      <= 1'b0;
                  end else begin
                     state   <= S_IDLE;
                     tx      <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state    <= S_IDLE;
               baud_cnt <= '0;
               tx       <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart1_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart1_transmitter
// Description : Self-checking bench for uart1_transmitter with
//               CLKS_PER_BIT=4 and FIFO_DEPTH=4. Register-access vectors and
//               single-frame line vectors are table driven; back-to-back,
//               overflow and mid-frame reset are hand-written sequences.
//               Honours UART1_PARITY_EN for the frame layout.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart1_transmitter;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART1_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic clk    = 1'b0;
   logic nRESET = 1'b0;
   logic tx;
   logic busy;

   uart1_transmitter_if bus ();

   uart1_transmitter #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk    (clk),
      .nRESET (nRESET),
      .bus    (bus),
      .tx     (tx),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- checks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------ bus tasks
   // All driving happens at a negedge; the next posedge is the active edge.
   task automatic idle_bus();
      bus.sel    = 1'b0;
      bus.write  = 1'b0;
      bus.read   = 1'b0;
      bus.offset = 12'h000;
      bus.wdata  = 8'h00;
   endtask

   task automatic do_write(input logic [7:0] d);
      bus.sel    = 1'b1;
      bus.write  = 1'b1;
      bus.read   = 1'b0;
      bus.offset = 12'h000;
      bus.wdata  = d;
      @(negedge clk);
      idle_bus();
   endtask

   task automatic do_read(input logic [11:0] off, output logic [7:0] d);
      bus.sel    = 1'b1;
      bus.write  = 1'b0;
      bus.read   = 1'b1;
      bus.offset = off;
      @(negedge clk);
      d = bus.rdata;
      idle_bus();
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic watch_idle(input string name, input int n);
      logic ok;
      ok = 1'b1;
      repeat (n) begin
         @(negedge clk);
         if (tx !== 1'b1) ok = 1'b0;
      end
      check(name, ok, 1'b1);
   endtask

   // ---------------------------------------------------- line monitor
   // Detects a start bit, samples each bit in its middle and queues the byte.
   logic [7:0] rx_q [$];
   int         rx_t [$];
   int         rx_err = 0;

   initial begin : line_monitor
      logic [7:0] b;
      logic       ok;
      int         t0;
      forever begin
         @(negedge clk);
         if (nRESET === 1'b1 && tx === 1'b0) begin
            t0 = cyc;
            ok = 1'b1;
            repeat (2) @(negedge clk);
            if (tx !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
`ifdef UART1_PARITY_EN
            repeat (CPB) @(negedge clk);
            if (tx !== ^b) ok = 1'b0;
`endif
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
            rx_q.push_back(b);
            rx_t.push_back(t0);
            if (!ok) rx_err++;
         end
      end
   end

   task automatic flush_rx();
      rx_q.delete();
      rx_t.delete();
      rx_err = 0;
   endtask

   task automatic wait_rx(input string name, input int n, input int budget);
      int w;
      w = 0;
      while ((rx_q.size() < n || busy !== 1'b0) && w < budget) begin
         @(negedge clk);
         w++;
      end
      if (w >= budget) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: actual=%0d frames required=%0d frames", name, rx_q.size(), n);
      end
   endtask

   // Expected line level of bit position i (0 = start) for a table entry.
   // seq holds the 8N1 bit sequence written left to right in send order.
   function automatic logic exp_bit(input logic [9:0] seq, input logic par, input int i);
`ifdef UART1_PARITY_EN
      if (i < 9)  return seq[9 - i];
      if (i == 9) return par;
      return seq[0];
`else
      return seq[9 - i];
`endif
   endfunction

   // ---------------------------------------------------- vector tables
   typedef struct {
      logic        sel;
      logic        wr;
      logic        rd;
      logic [11:0] off;
      logic [7:0]  wd;
      logic [7:0]  exp;
   } reg_vec_t;

   typedef struct {
      logic [7:0]  d;
      logic [9:0]  seq;
      logic        par;
   } frame_vec_t;

   reg_vec_t   rv [12];
   frame_vec_t fv [6];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [7:0] rd;
      logic       ok;
      logic       act;
      logic       e;
      logic [7:0] exp_bytes [$];

      // register access vectors: {sel, write, read, offset, wdata, expected rdata}
      rv[0]  = '{1'b1, 1'b0, 1'b1, 12'h004, 8'h00, 8'h02};
      rv[1]  = '{1'b0, 1'b0, 1'b1, 12'h004, 8'h00, 8'h00};
      rv[2]  = '{1'b1, 1'b0, 1'b1, 12'h004, 8'h00, 8'h02};
      rv[3]  = '{1'b1, 1'b0, 1'b1, 12'h010, 8'h00, 8'h00};
      rv[4]  = '{1'b1, 1'b0, 1'b1, 12'h004, 8'h00, 8'h02};
      rv[5]  = '{1'b1, 1'b0, 1'b1, 12'h000, 8'h00, 8'h00};
      rv[6]  = '{1'b1, 1'b1, 1'b0, 12'h004, 8'h55, 8'h00};
      rv[7]  = '{1'b1, 1'b1, 1'b0, 12'h010, 8'h55, 8'h00};
      rv[8]  = '{1'b0, 1'b1, 1'b0, 12'h000, 8'h55, 8'h00};
      rv[9]  = '{1'b1, 1'b0, 1'b1, 12'h004, 8'h00, 8'h02};
      rv[10] = '{1'b1, 1'b0, 1'b1, 12'h008, 8'h00, 8'h00};
      rv[11] = '{1'b1, 1'b0, 1'b1, 12'hFFC, 8'h00, 8'h00};

      // single-frame vectors: {byte, send-order 8N1 bits, even parity bit}
      fv[0] = '{8'hA5, 10'b0101001011, 1'b0};
      fv[1] = '{8'h00, 10'b0000000001, 1'b0};
      fv[2] = '{8'hFF, 10'b0111111111, 1'b0};
      fv[3] = '{8'h01, 10'b0100000001, 1'b1};
      fv[4] = '{8'h80, 10'b0000000011, 1'b1};
      fv[5] = '{8'h07, 10'b0111000001, 1'b1};

      // ---------------- reset and idle
      idle_bus();
      nRESET = 1'b0;
      step(2);
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_rdata", bus.rdata, 8'h00);
      nRESET = 1'b1;

      for (int i = 0; i < 12; i++) begin
         bus.sel    = rv[i].sel;
         bus.write  = rv[i].wr;
         bus.read   = rv[i].rd;
         bus.offset = rv[i].off;
         bus.wdata  = rv[i].wd;
         @(negedge clk);
         if (rv[i].rd) check($sformatf("regvec%0d_rdata", i), bus.rdata, rv[i].exp);
         idle_bus();
      end
      check("idle_tx", tx, 1'b1);
      step(2);

      // ---------------- single frames with exact latency
      for (int f = 0; f < 6; f++) begin
         flush_rx();
         do_write(fv[f].d);                         // now just after edge k
         check($sformatf("frame%0d_tx_before_k1", f), tx, 1'b1);
         for (int i = 0; i < NBITS; i++) begin
            e   = exp_bit(fv[f].seq, fv[f].par, i);
            act = e;
            for (int c = 0; c < CPB; c++) begin
               @(negedge clk);
               if (tx !== e && act === e) act = tx;
            end
            check($sformatf("frame%0d_bit%0d", f, i), act, e);
         end
         check($sformatf("frame%0d_busy_last", f), busy, 1'b1);
         @(negedge clk);                             // just after edge k+1+FRAME
         check($sformatf("frame%0d_busy_drop", f), busy, 1'b0);
         check($sformatf("frame%0d_tx_idle", f), tx, 1'b1);
         step(3);
      end

      // ---------------- back-to-back frames
      flush_rx();
      do_write(8'h31);
      do_write(8'h32);
      do_write(8'h33);
      wait_rx("b2b", 3, 3 * FRAME + 40);
      check("b2b_count", rx_q.size(), 3);
      if (rx_q.size() == 3) begin
         check("b2b_byte0", rx_q[0], 8'h31);
         check("b2b_byte1", rx_q[1], 8'h32);
         check("b2b_byte2", rx_q[2], 8'h33);
         check("b2b_gap01", rx_t[1] - rx_t[0], FRAME);
         check("b2b_gap12", rx_t[2] - rx_t[1], FRAME);
      end
      check("b2b_framing", rx_err, 0);
      step(3);

      // ---------------- overflow and push-with-pop at full
      flush_rx();
      for (int i = 0; i < 6; i++) do_write(8'h41 + 8'(i));   // edges k..k+5
      do_read(12'h004, rd);                                   // k+6
      check("ovf_status_set", rd, 8'h0D);
      do_read(12'h004, rd);                                   // k+7
      check("ovf_status_cleared", rd, 8'h05);
      // write and read together at TXDATA while full: both act (k+8)
      bus.sel    = 1'b1;
      bus.write  = 1'b1;
      bus.read   = 1'b1;
      bus.offset = 12'h000;
      bus.wdata  = 8'h47;
      @(negedge clk);
      idle_bus();
      check("wr_rd_same_edge_rdata", bus.rdata, 8'h00);
      do_read(12'h004, rd);                                   // k+9
      check("ovf_status_reset_again", rd, 8'h0D);
      do_read(12'h004, rd);                                   // k+10
      check("ovf_status_cleared2", rd, 8'h05);
      step(FRAME - 10);                                       // just after k+FRAME
      do_write(8'h48);                                        // edge k+FRAME+1 pops too
      do_read(12'h004, rd);
      check("push_pop_full_status", rd, 8'h05);
      exp_bytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h48};
      wait_rx("ovf", 6, 6 * FRAME + 60);
      check("ovf_count", rx_q.size(), 6);
      if (rx_q.size() == 6) begin
         for (int i = 0; i < 6; i++) check($sformatf("ovf_byte%0d", i), rx_q[i], exp_bytes[i]);
      end
      check("ovf_framing", rx_err, 0);
      do_read(12'h004, rd);
      check("ovf_drained_status", rd, 8'h02);

      // ---------------- reset mid-frame, all-ones byte
      flush_rx();
      do_write(8'hFF);                 // after edge k
      step(17);                        // after edge k+17, inside data bit 3
      nRESET = 1'b0;
      @(negedge clk);                  // after edge k+18
      check("rst_ff_tx", tx, 1'b1);
      check("rst_ff_busy", busy, 1'b0);
      nRESET = 1'b1;
      do_read(12'h004, rd);
      check("rst_ff_status", rd, 8'h02);
      watch_idle("rst_ff_quiet", 2 * FRAME);

      // ---------------- reset mid-frame, line low, second byte queued
      do_write(8'h00);                 // edge k
      do_write(8'h55);                 // edge k+1
      step(16);                        // after edge k+17
      check("rst_00_tx_low_before", tx, 1'b0);
      nRESET = 1'b0;
      @(negedge clk);
      check("rst_00_tx", tx, 1'b1);
      check("rst_00_busy", busy, 1'b0);
      nRESET = 1'b1;
      do_read(12'h004, rd);
      check("rst_00_status", rd, 8'h02);
      watch_idle("rst_00_quiet", 3 * FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
